// File: rtl/sensor_frame_timing_pkg.sv
// Shared definitions for the sensor frame timing block: FSM state encoding
// and the default counter widths / expected frame geometry.
package sensor_frame_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_IN_FRAME   = 2'd2
  } state_t;

  localparam int DEF_PIX_W      = 12;
  localparam int DEF_LINE_W     = 12;
  localparam int DEF_EXP_PIXELS = 1280;
  localparam int DEF_EXP_LINES  = 720;

endpackage

// File: rtl/sensor_frame_timing_sync_edge_detect.sv
// sync_edge_detect: one-flop history of an already-synchronized strobe and
// combinational rise/fall decode against that history.
module sync_edge_detect (
  input  logic clock,
  input  logic resetn,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic sig_q;

  // History register: previous-cycle level of the strobe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_in;
    end
  end

  assign rise = sig_in & ~sig_q;
  assign fall = ~sig_in & sig_q;

endmodule

// File: rtl/sensor_frame_timing.sv
// sensor_frame_timing: turns synchronized FVAL/LVAL strobes into registered
// frame/line start/end pulses, a per-pixel valid, position counters and
// line/frame size checking.
// Optional build macro: SENSOR_TIMING_ERR_CNT_EN enables the saturating
// err_count of frames that carried a size error; without it err_count is 0.
module sensor_frame_timing
  import sensor_frame_timing_pkg::*;
#(
  parameter int PIX_W      = DEF_PIX_W,
  parameter int LINE_W     = DEF_LINE_W,
  parameter int EXP_PIXELS = DEF_EXP_PIXELS,
  parameter int EXP_LINES  = DEF_EXP_LINES
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  input  logic              err_clr,
  input  logic              fval_sync,
  input  logic              lval_sync,
  output logic              frame_start,
  output logic              frame_end,
  output logic              line_start,
  output logic              line_end,
  output logic              pixel_valid,
  output logic [PIX_W-1:0]  pixel_x,
  output logic [LINE_W-1:0] line_y,
  output logic [PIX_W-1:0]  last_line_len,
  output logic [LINE_W-1:0] frame_lines,
  output logic              size_err,
  output logic [7:0]        err_count,
  output logic              busy
);

  localparam logic [PIX_W-1:0]  PIX_MAX    = '1;
  localparam logic [LINE_W-1:0] LINE_MAX   = '1;
  localparam logic [PIX_W-1:0]  EXP_PIX_V  = PIX_W'(EXP_PIXELS);
  localparam logic [LINE_W-1:0] EXP_LINE_V = LINE_W'(EXP_LINES);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [PIX_W-1:0] sat_inc_pix(input logic [PIX_W-1:0] v);
    return (v == PIX_MAX) ? v : v + PIX_W'(1);
  endfunction

  function automatic logic [LINE_W-1:0] sat_inc_line(input logic [LINE_W-1:0] v);
    return (v == LINE_MAX) ? v : v + LINE_W'(1);
  endfunction

  state_t             state;
  logic               fval_rise, fval_fall, lval_rise, lval_fall;
  logic               line_open;
  logic [PIX_W-1:0]   pix_cnt;

  logic               in_frame_p0, frame_go_p0, frame_done_p0;
  logic               pix_vld_p0, line_go_p0, line_done_p0;
  logic [PIX_W-1:0]   pix_cnt_nxt_p0;
  logic [LINE_W-1:0]  lines_nxt_p0, frame_lines_nxt_p0;
  logic               pix_ovf_p0, line_ovf_p0, len_bad_p0, frame_bad_p0, err_any_p0;

  sync_edge_detect u_fval_edge (
    .clock  (clock),
    .resetn (resetn),
    .sig_in (fval_sync),
    .rise   (fval_rise),
    .fall   (fval_fall)
  );

  sync_edge_detect u_lval_edge (
    .clock  (clock),
    .resetn (resetn),
    .sig_in (lval_sync),
    .rise   (lval_rise),
    .fall   (lval_fall)
  );

  // ---- stage p0: decode edges against the current state ----
  // A line is only opened by an LVAL rise inside a frame; line_open keeps a
  // level that was already high at frame start from being counted as pixels.
  always_comb begin
    in_frame_p0        = (state == ST_IN_FRAME);
    frame_go_p0        = (state == ST_WAIT_FRAME) && enable && fval_rise;
    frame_done_p0      = in_frame_p0 && fval_fall;
    pix_vld_p0         = in_frame_p0 && fval_sync && lval_sync && (line_open || lval_rise);
    line_go_p0         = pix_vld_p0 && !line_open;
    line_done_p0       = in_frame_p0 && line_open && (lval_fall || fval_fall);
    pix_cnt_nxt_p0     = line_go_p0 ? PIX_W'(1) : sat_inc_pix(pix_cnt);
    lines_nxt_p0       = sat_inc_line(line_y);
    frame_lines_nxt_p0 = line_done_p0 ? lines_nxt_p0 : line_y;
    pix_ovf_p0         = pix_vld_p0 && (pix_cnt_nxt_p0 == PIX_MAX);
    line_ovf_p0        = line_done_p0 && (lines_nxt_p0 == LINE_MAX);
    len_bad_p0         = line_done_p0 && (pix_cnt != EXP_PIX_V);
    frame_bad_p0       = frame_done_p0 && (frame_lines_nxt_p0 != EXP_LINE_V);
    err_any_p0         = pix_ovf_p0 || line_ovf_p0 || len_bad_p0 || frame_bad_p0;
  end

  // ---- stage p1: registered outputs ----
  // Frame FSM with registered frame pulses, frame_lines and busy.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_lines <= '0;
      busy        <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_WAIT_FRAME;
          end
        end
        ST_WAIT_FRAME: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (frame_go_p0) begin
            state       <= ST_IN_FRAME;
            frame_start <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ST_IN_FRAME: begin
          // enable is only consulted once the frame has closed
          if (frame_done_p0) begin
            frame_end   <= 1'b1;
            frame_lines <= frame_lines_nxt_p0;
            busy        <= 1'b0;
            state       <= enable ? ST_WAIT_FRAME : ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Line/pixel datapath: pulses, position counters and last line length.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      line_start    <= 1'b0;
      line_end      <= 1'b0;
      pixel_valid   <= 1'b0;
      pixel_x       <= '0;
      line_y        <= '0;
      last_line_len <= '0;
      pix_cnt       <= '0;
      line_open     <= 1'b0;
    end else begin
      line_start  <= line_go_p0;
      line_end    <= line_done_p0;
      pixel_valid <= pix_vld_p0;
      if (frame_go_p0) begin
        line_y    <= '0;
        line_open <= 1'b0;
      end else begin
        if (pix_vld_p0) begin
          pix_cnt <= pix_cnt_nxt_p0;
          pixel_x <= line_go_p0 ? '0 : sat_inc_pix(pixel_x);
        end
        if (line_go_p0) begin
          line_open <= 1'b1;
        end
        if (line_done_p0) begin
          line_open     <= 1'b0;
          last_line_len <= pix_cnt;
          line_y        <= lines_nxt_p0;
        end
      end
    end
  end

  // Sticky size error; a new error outranks a coincident clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      size_err <= 1'b0;
    end else if (err_any_p0) begin
      size_err <= 1'b1;
    end else if (err_clr) begin
      size_err <= 1'b0;
    end
  end

`ifdef SENSOR_TIMING_ERR_CNT_EN
  logic frame_err;

  // Per-frame error flag (independent of err_clr) and saturating frame error count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      if (frame_go_p0) begin
        frame_err <= 1'b0;
      end else if (err_any_p0) begin
        frame_err <= 1'b1;
      end
      if (frame_done_p0 && (frame_err || err_any_p0)) begin
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end else if (err_clr) begin
        err_count <= '0;
      end
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_sensor_frame_timing.sv
// Bench for sensor_frame_timing with a reduced geometry (12 px x 6 lines,
// 5-bit pixel and 4-bit line counters) so saturation is reachable.
module tb_sensor_frame_timing;

  localparam int PIX_W      = 5;
  localparam int LINE_W     = 4;
  localparam int EXP_PIXELS = 12;
  localparam int EXP_LINES  = 6;
  localparam int PMAX       = (1 << PIX_W) - 1;
  localparam int LMAX       = (1 << LINE_W) - 1;
`ifdef SENSOR_TIMING_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              enable = 1'b0;
  logic              err_clr = 1'b0;
  logic              fval_sync = 1'b0;
  logic              lval_sync = 1'b0;
  logic              frame_start, frame_end, line_start, line_end, pixel_valid;
  logic [PIX_W-1:0]  pixel_x, last_line_len;
  logic [LINE_W-1:0] line_y, frame_lines;
  logic              size_err, busy;
  logic [7:0]        err_count;

  int n_vec = 0;
  int n_bad = 0;

  // observation record, filled while stimulus is driven
  int fs_cnt, fe_cnt, ls_cnt, le_cnt, pv_cnt, px_seq_bad, both_end_cnt, px_run;
  int len_q[$];
  int fl_q[$];

  always #5 clock = ~clock;

  sensor_frame_timing #(
    .PIX_W(PIX_W), .LINE_W(LINE_W), .EXP_PIXELS(EXP_PIXELS), .EXP_LINES(EXP_LINES)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .err_clr(err_clr),
    .fval_sync(fval_sync), .lval_sync(lval_sync),
    .frame_start(frame_start), .frame_end(frame_end), .line_start(line_start),
    .line_end(line_end), .pixel_valid(pixel_valid), .pixel_x(pixel_x),
    .line_y(line_y), .last_line_len(last_line_len), .frame_lines(frame_lines),
    .size_err(size_err), .err_count(err_count), .busy(busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Reference rule: a frame is in error if any line length or the line count
  // is off, or a counter reached all-ones.
  function automatic bit frame_has_err(input int lens[$]);
    bit bad;
    bad = (lens.size() != EXP_LINES) || (lens.size() >= LMAX);
    foreach (lens[i]) if (lens[i] != EXP_PIXELS || lens[i] >= PMAX) bad = 1'b1;
    return bad;
  endfunction

  task automatic clear_rec();
    fs_cnt = 0; fe_cnt = 0; ls_cnt = 0; le_cnt = 0; pv_cnt = 0;
    px_seq_bad = 0; both_end_cnt = 0; px_run = 0;
    len_q.delete(); fl_q.delete();
  endtask

  // One cycle: record outputs produced by the last edge, then drive new inputs.
  task automatic tick(input logic f, input logic l, input logic c = 1'b0);
    @(negedge clock);
    if (frame_start) fs_cnt++;
    if (frame_end) begin
      fe_cnt++;
      fl_q.push_back(int'(frame_lines));
      if (line_end) both_end_cnt++;
    end
    if (line_start) px_run = 0;
    else if (pixel_valid) px_run++;
    if (pixel_valid) begin
      pv_cnt++;
      if (int'(pixel_x) != sat(px_run, PMAX)) px_seq_bad++;
    end
    if (line_start) ls_cnt++;
    if (line_end) begin
      le_cnt++;
      len_q.push_back(int'(last_line_len));
    end
    fval_sync = f;
    lval_sync = l;
    err_clr   = c;
  endtask

  // mode 0: normal blanking before fval fall; 1: last line's lval and fval
  // fall together; 2: fval falls while lval is still high.
  task automatic send_frame(input int lens[$], input int gap, input int mode, input int drop_line);
    tick(1, 0); tick(1, 0);
    foreach (lens[i]) begin
      if (i == drop_line) enable = 1'b0;
      for (int k = 0; k < lens[i]; k++) tick(1, 1);
      if (i == lens.size() - 1 && mode == 2) tick(0, 1);
      else if (!(i == lens.size() - 1 && mode == 1))
        for (int g = 0; g < gap; g++) tick(1, 0);
    end
    for (int k = 0; k < 4; k++) tick(0, 0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) tick(0, 0);
    n_vec++;
    if ({frame_start, frame_end, line_start, line_end, pixel_valid, pixel_x, line_y,
         last_line_len, frame_lines, size_err, err_count, busy} !== '0) begin
      n_bad++; $display("FAIL reset.outputs got nonzero want all 0 (busy=%b size_err=%b)", busy, size_err);
    end
    resetn = 1'b1;
    tick(0, 0);
    n_vec++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset.busy got %b want 0", busy); end
  endtask

  task automatic test_latency();
    clear_rec();
    enable = 1'b1;
    tick(0, 0); tick(0, 0);
    tick(1, 0);
    n_vec++;
    if (frame_start !== 1'b0) begin n_bad++; $display("FAIL latency.early_start got %b want 0", frame_start); end
    tick(1, 0);
    n_vec++;
    if ({frame_start, busy} !== 2'b11) begin n_bad++; $display("FAIL latency.start_busy got %b want 11", {frame_start, busy}); end
    tick(1, 1); tick(1, 1);
    n_vec++;
    if ({line_start, pixel_valid} !== 2'b11 || pixel_x !== '0) begin
      n_bad++; $display("FAIL latency.line_start got ls=%b pv=%b x=%0d want 1 1 0", line_start, pixel_valid, pixel_x);
    end
    tick(1, 0);
    tick(1, 0);
    n_vec++;
    if (line_end !== 1'b1 || int'(last_line_len) != 2) begin
      n_bad++; $display("FAIL latency.line_end got le=%b len=%0d want 1 2", line_end, last_line_len);
    end
    for (int k = 0; k < 4; k++) tick(0, 0);
    n_vec++;
    if (fe_cnt != 1 || fl_q.size() != 1 || fl_q[0] != 1) begin
      n_bad++; $display("FAIL latency.frame_end got fe=%0d lines=%0d want 1 1", fe_cnt, (fl_q.size() > 0) ? fl_q[0] : -1);
    end
  endtask

  task automatic test_nominal();
    int lens[$];
    lens = {12, 12, 12, 12, 12, 12};
    tick(0, 0, 1); tick(0, 0);
    clear_rec();
    send_frame(lens, 2, 0, -1);
    n_vec++; if (fs_cnt != 1) begin n_bad++; $display("FAIL nominal.frame_start got %0d want 1", fs_cnt); end
    n_vec++; if (ls_cnt != 6 || le_cnt != 6) begin n_bad++; $display("FAIL nominal.line_pulses got %0d/%0d want 6/6", ls_cnt, le_cnt); end
    n_vec++; if (fl_q.size() != 1 || fl_q[0] != 6) begin n_bad++; $display("FAIL nominal.frame_lines got %0d want 6", (fl_q.size() > 0) ? fl_q[0] : -1); end
    n_vec++; if (len_q.size() != 6 || len_q[5] != 12) begin n_bad++; $display("FAIL nominal.last_line_len got %0d want 12", int'(last_line_len)); end
    n_vec++; if (size_err !== 1'b0) begin n_bad++; $display("FAIL nominal.size_err got %b want 0", size_err); end
    n_vec++; if (pv_cnt != 72 || px_seq_bad != 0) begin n_bad++; $display("FAIL nominal.pixels got %0d bad_idx=%0d want 72 0", pv_cnt, px_seq_bad); end
    n_vec++; if (int'(line_y) != 6 || busy !== 1'b0) begin n_bad++; $display("FAIL nominal.line_y_busy got %0d %b want 6 0", line_y, busy); end
  endtask

  task automatic test_short_line();
    int lens[$];
    lens = {12, 12, 11, 12, 12, 12};
    clear_rec();
    send_frame(lens, 1, 0, -1);
    n_vec++; if (len_q.size() != 6 || len_q[2] != 11) begin n_bad++; $display("FAIL short.len got %0d want 11", (len_q.size() > 2) ? len_q[2] : -1); end
    n_vec++; if (size_err !== 1'b1) begin n_bad++; $display("FAIL short.size_err got %b want 1", size_err); end
    n_vec++; if (int'(err_count) != (CNT_EN ? 1 : 0)) begin n_bad++; $display("FAIL short.err_count got %0d want %0d", err_count, CNT_EN ? 1 : 0); end
    tick(0, 0, 1); tick(0, 0);
    n_vec++; if ({size_err, err_count} !== 9'd0) begin n_bad++; $display("FAIL short.clear got %b/%0d want 0/0", size_err, err_count); end
    // error at line end coincides with err_clr: the error must stick
    tick(1, 0); tick(1, 0);
    for (int k = 0; k < 5; k++) tick(1, 1);
    tick(1, 0, 1);
    tick(1, 0);
    tick(1, 0);
    n_vec++; if (size_err !== 1'b1) begin n_bad++; $display("FAIL short.set_wins got %b want 1", size_err); end
    for (int k = 0; k < 4; k++) tick(0, 0);
  endtask

  task automatic test_enable_late();
    int lens[$];
    lens = {12, 12, 12, 12, 12, 12};
    enable = 1'b0;
    tick(0, 0); tick(0, 0);
    clear_rec();
    tick(1, 0); tick(1, 0);
    for (int k = 0; k < 12; k++) tick(1, 1);
    tick(1, 0);
    enable = 1'b1;
    tick(1, 0);
    for (int k = 0; k < 12; k++) tick(1, 1);
    tick(1, 0);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL late.busy got %b want 0", busy); end
    for (int k = 0; k < 4; k++) tick(0, 0);
    n_vec++;
    if (fs_cnt + fe_cnt + ls_cnt + le_cnt + pv_cnt != 0) begin
      n_bad++; $display("FAIL late.ignored got fs=%0d fe=%0d ls=%0d le=%0d pv=%0d want all 0", fs_cnt, fe_cnt, ls_cnt, le_cnt, pv_cnt);
    end
    tick(0, 0, 1); tick(0, 0);
    clear_rec();
    send_frame(lens, 3, 0, -1);
    n_vec++;
    if (fs_cnt != 1 || fe_cnt != 1 || ls_cnt != 6 || fl_q.size() != 1 || fl_q[0] != 6 || size_err !== 1'b0) begin
      n_bad++; $display("FAIL late.next_frame got fs=%0d fe=%0d ls=%0d err=%b want 1 1 6 0", fs_cnt, fe_cnt, ls_cnt, size_err);
    end
  endtask

  task automatic test_simul_fall();
    int lens[$];
    lens = {12, 12, 12, 12, 12, 12};
    for (int m = 1; m <= 2; m++) begin
      tick(0, 0, 1); tick(0, 0);
      clear_rec();
      send_frame(lens, 1, m, -1);
      n_vec++;
      if (both_end_cnt != 1 || le_cnt != 6 || fl_q.size() != 1 || fl_q[0] != 6) begin
        n_bad++; $display("FAIL simul_fall.m%0d got both=%0d le=%0d lines=%0d want 1 6 6", m, both_end_cnt, le_cnt, (fl_q.size() > 0) ? fl_q[0] : -1);
      end
      n_vec++;
      if (len_q.size() != 6 || len_q[5] != 12 || size_err !== 1'b0) begin
        n_bad++; $display("FAIL simul_fall.len_m%0d got len=%0d err=%b want 12 0", m, int'(last_line_len), size_err);
      end
    end
  endtask

  task automatic test_enable_drop();
    int lens[$];
    lens = {12, 12, 12, 12, 12, 12};
    clear_rec();
    send_frame(lens, 1, 0, 2);
    n_vec++;
    if (fe_cnt != 1 || fl_q.size() != 1 || fl_q[0] != 6 || busy !== 1'b0) begin
      n_bad++; $display("FAIL drop.frame_completes got fe=%0d lines=%0d busy=%b want 1 6 0", fe_cnt, (fl_q.size() > 0) ? fl_q[0] : -1, busy);
    end
    clear_rec();
    send_frame(lens, 1, 0, -1);
    n_vec++;
    if (fs_cnt + ls_cnt + pv_cnt + fe_cnt != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL drop.next_ignored got fs=%0d ls=%0d pv=%0d fe=%0d want all 0", fs_cnt, ls_cnt, pv_cnt, fe_cnt);
    end
    enable = 1'b1;
    tick(0, 0); tick(0, 0);
  endtask

  task automatic test_saturation();
    int lens[$];
    lens = {40, 3};
    tick(0, 0, 1); tick(0, 0);
    clear_rec();
    send_frame(lens, 2, 0, -1);
    n_vec++;
    if (len_q.size() != 2 || len_q[0] != PMAX || px_seq_bad != 0 || size_err !== 1'b1) begin
      n_bad++; $display("FAIL sat.pixel got len=%0d bad_idx=%0d err=%b want %0d 0 1", (len_q.size() > 0) ? len_q[0] : -1, px_seq_bad, size_err, PMAX);
    end
    lens.delete();
    for (int i = 0; i < 17; i++) lens.push_back(2);
    tick(0, 0, 1); tick(0, 0);
    clear_rec();
    send_frame(lens, 1, 0, -1);
    n_vec++;
    if (fl_q.size() != 1 || fl_q[0] != LMAX || int'(line_y) != LMAX || size_err !== 1'b1) begin
      n_bad++; $display("FAIL sat.lines got %0d y=%0d err=%b want %0d %0d 1", (fl_q.size() > 0) ? fl_q[0] : -1, line_y, size_err, LMAX, LMAX);
    end
  endtask

  task automatic test_async_reset();
    int lens[$];
    lens = {12, 12, 12, 12, 12, 12};
    tick(1, 0); tick(1, 0);
    for (int k = 0; k < 4; k++) tick(1, 1);
    n_vec++; if (pixel_valid !== 1'b1) begin n_bad++; $display("FAIL areset.pre got pv=%b want 1", pixel_valid); end
    #2 resetn = 1'b0;
    #1;
    n_vec++;
    if ({frame_start, frame_end, line_start, line_end, pixel_valid, pixel_x, line_y,
         last_line_len, frame_lines, size_err, err_count, busy} !== '0) begin
      n_bad++; $display("FAIL areset.immediate got pv=%b x=%0d busy=%b want 0 0 0", pixel_valid, pixel_x, busy);
    end
    tick(1, 1); tick(1, 1);
    resetn = 1'b1;
    clear_rec();
    for (int k = 0; k < 3; k++) tick(1, 1);
    tick(1, 0);
    for (int k = 0; k < 5; k++) tick(1, 1);
    tick(1, 0);
    for (int k = 0; k < 4; k++) tick(0, 0);
    n_vec++;
    if (fs_cnt + ls_cnt + pv_cnt + fe_cnt != 0) begin
      n_bad++; $display("FAIL areset.partial got fs=%0d ls=%0d pv=%0d fe=%0d want all 0", fs_cnt, ls_cnt, pv_cnt, fe_cnt);
    end
    clear_rec();
    send_frame(lens, 1, 0, -1);
    n_vec++;
    if (fs_cnt != 1 || fl_q.size() != 1 || fl_q[0] != 6 || size_err !== 1'b0) begin
      n_bad++; $display("FAIL areset.resume got fs=%0d lines=%0d err=%b want 1 6 0", fs_cnt, (fl_q.size() > 0) ? fl_q[0] : -1, size_err);
    end
  endtask

  task automatic test_random();
    int lens[$];
    int nl, sum, gap, mode, bad_len;
    bit exp_err;
    for (int f = 0; f < 15; f++) begin
      lens.delete();
      nl  = $urandom_range(4, 8);
      sum = 0;
      for (int i = 0; i < nl; i++) begin
        lens.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 15)) : EXP_PIXELS);
        sum += lens[i];
      end
      gap     = $urandom_range(1, 3);
      mode    = $urandom_range(0, 2);
      exp_err = frame_has_err(lens);
      tick(0, 0, 1); tick(0, 0);
      clear_rec();
      send_frame(lens, gap, mode, -1);
      n_vec++;
      if (fs_cnt != 1 || fe_cnt != 1 || ls_cnt != nl || le_cnt != nl) begin
        n_bad++; $display("FAIL rand%0d.pulses got fs=%0d fe=%0d ls=%0d le=%0d want 1 1 %0d %0d", f, fs_cnt, fe_cnt, ls_cnt, le_cnt, nl, nl);
      end
      n_vec++;
      if (fl_q.size() != 1 || fl_q[0] != sat(nl, LMAX)) begin
        n_bad++; $display("FAIL rand%0d.frame_lines got %0d want %0d", f, (fl_q.size() > 0) ? fl_q[0] : -1, sat(nl, LMAX));
      end
      bad_len = 0;
      foreach (lens[i]) if (i >= len_q.size() || len_q[i] != sat(lens[i], PMAX)) bad_len++;
      n_vec++;
      if (bad_len != 0 || pv_cnt != sum || px_seq_bad != 0) begin
        n_bad++; $display("FAIL rand%0d.lines got bad_len=%0d pv=%0d bad_idx=%0d want 0 %0d 0", f, bad_len, pv_cnt, px_seq_bad, sum);
      end
      n_vec++;
      if (size_err !== exp_err || int'(err_count) != ((CNT_EN && exp_err) ? 1 : 0)) begin
        n_bad++; $display("FAIL rand%0d.err got %b/%0d want %b/%0d", f, size_err, err_count, exp_err, (CNT_EN && exp_err) ? 1 : 0);
      end
    end
  endtask

  initial begin
    clear_rec();
    test_reset();
    test_latency();
    test_nominal();
    test_short_line();
    test_enable_late();
    test_simul_fall();
    test_enable_drop();
    test_saturation();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
